// File: rtl/mips_mem_arb_pkg.sv
// Shared types and constants for the two-port MIPS memory arbiter.
// Imported by the arbiter top and its watchdog.
package mips_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        I_ACC,
        D_ACC,
        RESP
    } arb_state_t;

    typedef enum logic {
        GRANT_INSTR,
        GRANT_DATA
    } grant_t;

    localparam logic [31:0] ARB_ERROR_WORD = 32'hDEADBEEF;
    localparam logic [3:0]  FULL_WORD_BE   = 4'b1111;

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// Avalon-style shared memory port: master is the arbiter, slave is the memory/bus.
interface mips_mem_arbiter_if;

    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    modport master (
        output mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        input  mem_readdata, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_writedata, mem_byteenable,
        output mem_readdata, mem_waitrequest
    );

endinterface

// File: rtl/mem_arb_watchdog.sv
// Counts consecutive stalled access cycles; expired is high on the cycle the
// count reaches TIMEOUT_CYCLES so the arbiter can abort on that edge.
module mem_arb_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en) begin
            count <= count + 16'd1;
        end
    end

    assign expired = count_en && (count == LAST_COUNT);

endmodule

// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one wait-request memory port between instruction
// fetch and data access. Define MEM_ARB_TIMEOUT_EN to compile in the stall watchdog.
module mips_mem_arbiter
    import mips_mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                instr_req,
    input  logic [31:0]         instr_address,
    output logic [31:0]         instr_readdata,
    output logic                instr_valid,

    input  logic                data_read,
    input  logic                data_write,
    input  logic [31:0]         data_address,
    input  logic [31:0]         data_writedata,
    input  logic [3:0]          data_byteenable,
    output logic [31:0]         data_readdata,
    output logic                data_done,

    mips_mem_arbiter_if.master  mem,

    output logic                bus_error
);

    arb_state_t  state, state_next;
    grant_t      last_grant, grant_next;
    logic [31:0] resp_q;
    logic        data_pend;
    logic        in_acc;
    logic        timeout_hit;
    logic        unused_bits;

    assign data_pend = data_read | data_write;
    assign in_acc    = (state == I_ACC) || (state == D_ACC);

`ifdef MEM_ARB_TIMEOUT_EN
    logic err_q;

    mem_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear    (!in_acc),
        .count_en (in_acc && mem.mem_waitrequest),
        .expired  (timeout_hit)
    );

    assign bus_error = (state == RESP) && err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_error   = 1'b0;
`endif

    assign unused_bits = ^{instr_address[1:0], (TIMEOUT_CYCLES == 0)};

    // Grant decision happens only in IDLE; on a tie the requester not served last wins.
    always_comb begin
        state_next = state;
        grant_next = last_grant;
        case (state)
            IDLE: begin
                if (instr_req && data_pend) begin
                    grant_next = (last_grant == GRANT_DATA) ? GRANT_INSTR : GRANT_DATA;
                end else if (instr_req) begin
                    grant_next = GRANT_INSTR;
                end else if (data_pend) begin
                    grant_next = GRANT_DATA;
                end
                if (instr_req || data_pend) begin
                    state_next = (grant_next == GRANT_INSTR) ? I_ACC : D_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (!mem.mem_waitrequest || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Memory strobes are registered: set on grant, held through ACC, dropped on exit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            last_grant         <= GRANT_DATA;
            resp_q             <= '0;
            mem.mem_address    <= '0;
            mem.mem_read       <= 1'b0;
            mem.mem_write      <= 1'b0;
            mem.mem_writedata  <= '0;
            mem.mem_byteenable <= '0;
        end else begin
            state      <= state_next;
            last_grant <= grant_next;

            if (state == IDLE && state_next == I_ACC) begin
                mem.mem_address    <= {instr_address[31:2], 2'b00};
                mem.mem_read       <= 1'b1;
                mem.mem_write      <= 1'b0;
                mem.mem_byteenable <= FULL_WORD_BE;
            end else if (state == IDLE && state_next == D_ACC) begin
                mem.mem_address    <= data_address;
                mem.mem_read       <= !data_write;
                mem.mem_write      <= data_write;
                mem.mem_writedata  <= data_writedata;
                mem.mem_byteenable <= data_byteenable;
            end else if (state_next != I_ACC && state_next != D_ACC) begin
                mem.mem_read  <= 1'b0;
                mem.mem_write <= 1'b0;
            end

            // Writes leave the response word untouched; aborts overwrite it.
            if (in_acc && !mem.mem_waitrequest) begin
                if (mem.mem_read) begin
                    resp_q <= mem.mem_readdata;
                end
            end else if (in_acc && timeout_hit) begin
                resp_q <= ARB_ERROR_WORD;
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (in_acc && !mem.mem_waitrequest) begin
            err_q <= 1'b0;
        end else if (in_acc && timeout_hit) begin
            err_q <= 1'b1;
        end
    end
`endif

    assign instr_valid    = (state == RESP) && (last_grant == GRANT_INSTR);
    assign data_done      = (state == RESP) && (last_grant == GRANT_DATA);
    assign instr_readdata = resp_q;
    assign data_readdata  = resp_q;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed self-checking bench for mips_mem_arbiter; inputs change and outputs
// are sampled on the falling clock edge.
module tb_mips_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_req;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_valid;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_done;
    logic        bus_error;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mips_mem_arbiter_if mem_bus ();

    mips_mem_arbiter #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_req       (instr_req),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .instr_valid     (instr_valid),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .data_done       (data_done),
        .mem             (mem_bus),
        .bus_error       (bus_error)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic [31:0] iaddr,
                                 input logic dread, input logic dwrite,
                                 input logic [31:0] daddr, input logic [31:0] wdata,
                                 input logic [3:0] be);
        instr_req       = ireq;
        instr_address   = iaddr;
        data_read       = dread;
        data_write      = dwrite;
        data_address    = daddr;
        data_writedata  = wdata;
        data_byteenable = be;
    endtask

    initial begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_bus.mem_waitrequest = 1'b0;
        mem_bus.mem_readdata    = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_read", 32'(mem_bus.mem_read), 32'd0);
        checkOutput("rst_mem_write", 32'(mem_bus.mem_write), 32'd0);
        checkOutput("rst_mem_address", mem_bus.mem_address, 32'h0);
        checkOutput("rst_instr_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_data_done", 32'(data_done), 32'd0);
        checkOutput("rst_bus_error", 32'(bus_error), 32'd0);
        checkOutput("rst_readdata", data_readdata, 32'h0);
        reset = 1'b1;

        // Single fetch with an unaligned address
        applyStimulus(1'b1, 32'hBFC00006, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        mem_bus.mem_readdata = 32'h24020005;
        @(negedge clk);
        checkOutput("fetch_mem_address", mem_bus.mem_address, 32'hBFC00004);
        checkOutput("fetch_mem_read", 32'(mem_bus.mem_read), 32'd1);
        checkOutput("fetch_mem_write", 32'(mem_bus.mem_write), 32'd0);
        checkOutput("fetch_byteenable", 32'(mem_bus.mem_byteenable), 32'hF);
        checkOutput("fetch_early_valid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        checkOutput("fetch_valid", 32'(instr_valid), 32'd1);
        checkOutput("fetch_readdata", instr_readdata, 32'h24020005);
        checkOutput("fetch_resp_mem_read", 32'(mem_bus.mem_read), 32'd0);
        checkOutput("fetch_data_done", 32'(data_done), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        checkOutput("fetch_idle_valid", 32'(instr_valid), 32'd0);

        // Contention from reset: I, D, I, D with pulses three cycles apart
        reset = 1'b0;
        applyStimulus(1'b1, 32'h00400003, 1'b1, 1'b0, 32'h10010002, 32'h0, 4'hF);
        mem_bus.mem_readdata = 32'h11112222;
        @(negedge clk);
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkOutput($sformatf("cont_ivalid_%0d", k), 32'(instr_valid), 32'((k % 6) == 2));
            checkOutput($sformatf("cont_ddone_%0d", k), 32'(data_done), 32'((k % 6) == 5));
            if ((k % 6) == 1)
                checkOutput($sformatf("cont_iaddr_%0d", k), mem_bus.mem_address, 32'h00400000);
            if ((k % 6) == 4)
                checkOutput($sformatf("cont_daddr_%0d", k), mem_bus.mem_address, 32'h10010002);
            if ((k % 6) == 5)
                checkOutput($sformatf("cont_drdata_%0d", k), data_readdata, 32'h11112222);
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Write with four wait states; write wins over a simultaneous read
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h00001000, 32'hCAFEF00D, 4'b0011);
        mem_bus.mem_waitrequest = 1'b1;
        mem_bus.mem_readdata    = 32'h55556666;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            checkOutput($sformatf("ws_mem_write_%0d", k), 32'(mem_bus.mem_write), 32'(k <= 5));
            checkOutput($sformatf("ws_mem_read_%0d", k), 32'(mem_bus.mem_read), 32'd0);
            checkOutput($sformatf("ws_ivalid_%0d", k), 32'(instr_valid), 32'd0);
            checkOutput($sformatf("ws_ddone_%0d", k), 32'(data_done), 32'(k == 6));
            if (k == 1) begin
                checkOutput("ws_address", mem_bus.mem_address, 32'h00001000);
                checkOutput("ws_byteenable", 32'(mem_bus.mem_byteenable), 32'h3);
                checkOutput("ws_writedata", mem_bus.mem_writedata, 32'hCAFEF00D);
            end
            if (k == 5) mem_bus.mem_waitrequest = 1'b0;
            if (k == 6) begin
                checkOutput("ws_readdata_held", data_readdata, 32'h11112222);
                applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            end
        end

        // Reset during an access, then the first tie goes to instruction
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h00002000, 32'h0, 4'hF);
        mem_bus.mem_readdata = 32'h33334444;
        @(negedge clk);
        checkOutput("mid_mem_read_before", 32'(mem_bus.mem_read), 32'd1);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_mem_read_async", 32'(mem_bus.mem_read), 32'd0);
        checkOutput("mid_mem_address_async", mem_bus.mem_address, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput($sformatf("mid_no_pulse_%0d", k), 32'(data_done | instr_valid), 32'd0);
        end
        applyStimulus(1'b1, 32'h00000010, 1'b1, 1'b0, 32'h00002000, 32'h0, 4'hF);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mid_tie_address", mem_bus.mem_address, 32'h00000010);
        checkOutput("mid_tie_mem_read", 32'(mem_bus.mem_read), 32'd1);
        @(negedge clk);
        checkOutput("mid_tie_ivalid", 32'(instr_valid), 32'd1);
        checkOutput("mid_tie_ddone", 32'(data_done), 32'd0);
        checkOutput("mid_tie_readdata", instr_readdata, 32'h33334444);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);

        // Stuck wait-request
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h00003000, 32'h0, 4'hF);
        mem_bus.mem_waitrequest = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
        begin
            int pulse_cycle = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (pulse_cycle == 0 && data_done) begin
                    pulse_cycle = k;
                    checkOutput("to_bus_error", 32'(bus_error), 32'd1);
                    checkOutput("to_readdata", data_readdata, 32'hDEADBEEF);
                    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
                end
            end
            checkOutput("to_pulse_cycle", 32'(pulse_cycle), 32'd9);
        end
`else
        begin
            int pulses = 0;
            int errs   = 0;
            for (int k = 0; k < 1000; k++) begin
                @(negedge clk);
                if (data_done || instr_valid) pulses++;
                if (bus_error) errs++;
            end
            checkOutput("stuck_pulses", 32'(pulses), 32'd0);
            checkOutput("stuck_bus_error", 32'(errs), 32'd0);
            checkOutput("stuck_mem_read", 32'(mem_bus.mem_read), 32'd1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
